// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the control-unit testbench.
package mem_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefLatency = 2;
  // Wait counter width; covers LATENCY up to 7.
  localparam int unsigned CntW       = 3;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // A byte address is usable only when it names the first byte of a word.
  function automatic logic is_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered (synchronous) read.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  word_t             wdata_i,
  output word_t             rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  word_t mem_q [Depth];
  word_t rdata_q;

  // Storage is deliberately not reset; contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency responder for the datapath memory port. Accepts one request at a
// time, answers after LATENCY wait cycles with a one-cycle rdy, and reports
// misaligned requests through err instead of performing them.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned LATENCY = DefLatency
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        rdy,
  output logic        err,
  output logic        busy
);

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..7");
  end

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mis_q, mis_d;
  word_t             wdata_q, wdata_d;
  word_t             rd_q, rd_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  word_t             ram_rdata;
  logic              finish;

  // Address bits above the word index are ignored, so addresses alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:ADDR_W+2];

  // Last WAIT cycle: the next edge enters RESP.
  assign finish = (state_q == WAIT) && (cnt_q == '0);

  // Present the incoming index while idle so the registered RAM read already
  // holds the right word by the time a LATENCY=1 request finishes.
  assign ram_addr = (state_q == IDLE) ? Address[ADDR_W+1:2] : idx_q;
  assign ram_we   = finish && wr_q && !mis_q;

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk_i   (Clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Next-state and registered-output logic for the request sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = CntW'(LATENCY - 1);
          wr_d    = wr;
          idx_d   = Address[ADDR_W+1:2];
          mis_d   = is_misaligned(Address);
          wdata_d = WriteData;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdy_d   = 1'b1;
          err_d   = mis_q;
          if (!wr_q && !mis_q) begin
            rd_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign ReadData = rd_q;
  assign rdy      = rdy_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 1, 7) share one input
// stream; the LATENCY=2 instance is tracked cycle by cycle by a transaction model.
module tb_mem_responder;

  localparam int LAT [3] = '{2, 1, 7};

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rd_o   [3];
  logic        rdy_o  [3];
  logic        err_o  [3];
  logic        busy_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  mem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .wr(wr), .Address(addr), .WriteData(wdata),
    .ReadData(rd_o[0]), .rdy(rdy_o[0]), .err(err_o[0]), .busy(busy_o[0])
  );
  mem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .wr(wr), .Address(addr), .WriteData(wdata),
    .ReadData(rd_o[1]), .rdy(rdy_o[1]), .err(err_o[1]), .busy(busy_o[1])
  );
  mem_responder #(.ADDR_W(8), .LATENCY(7)) u_l7 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .wr(wr), .Address(addr), .WriteData(wdata),
    .ReadData(rd_o[2]), .rdy(rdy_o[2]), .err(err_o[2]), .busy(busy_o[2])
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model of the LATENCY=2 instance ----------------
  bit          m_busy = 1'b0;
  int          m_age = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_rd = '0;
  bit          m_rd_known = 1'b1;
  logic [31:0] m_mem [int];

  initial begin
    int idx;
    bit exp_rdy;
    forever begin
      @(posedge Clk);
      if (Reset_n) begin
        if (!m_busy) begin
          if (req === 1'b1) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_wr   = wr;
            m_addr = addr;
            m_data = wdata;
          end
        end else begin
          m_age++;
          if (m_age == LAT[0]) begin
            idx = int'((m_addr >> 2) % 256);
            if (m_addr % 4 == 0) begin
              if (m_wr) begin
                m_mem[idx] = m_data;
              end else if (m_mem.exists(idx)) begin
                m_rd = m_mem[idx];
                m_rd_known = 1'b1;
              end else begin
                m_rd_known = 1'b0;
              end
            end
          end else if (m_age > LAT[0]) begin
            m_busy = 1'b0;
          end
        end
      end
      @(negedge Clk);
      if (!Reset_n) begin
        m_busy = 1'b0;
        m_age  = 0;
        m_rd   = '0;
        m_rd_known = 1'b1;
      end
      exp_rdy = m_busy && (m_age == LAT[0]);
      cmp("model_busy", busy_o[0], m_busy);
      cmp("model_rdy", rdy_o[0], exp_rdy);
      cmp("model_err", err_o[0], exp_rdy && (m_addr % 4 != 0));
      if (m_rd_known) cmp("model_rdata", rd_o[0], m_rd);
    end
  end

  // ---------------- directed access helper ----------------
  bit          got    [3];
  int          lat    [3];
  int          bcnt   [3];
  int          npulse [3];
  logic [31:0] r_rd   [3];
  logic        r_err  [3];

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) cmp("idle_timeout", 1, 0);
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    req = 1'b1; wr = w; addr = a; wdata = d;
    for (int i = 0; i < 3; i++) begin
      got[i] = 1'b0; lat[i] = 0; bcnt[i] = 0; npulse[i] = 0;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 1) req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (busy_o[i]) bcnt[i]++;
        if (rdy_o[i]) begin
          npulse[i]++;
          if (!got[i]) begin
            got[i] = 1'b1; lat[i] = c; r_rd[i] = rd_o[i]; r_err[i] = err_o[i];
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("rdy_seen_u%0d", i), 32'(got[i]), 1);
      cmp($sformatf("latency_u%0d", i), lat[i], LAT[i] + 1);
      cmp($sformatf("busy_len_u%0d", i), bcnt[i], LAT[i] + 1);
      cmp($sformatf("rdy_pulses_u%0d", i), npulse[i], 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rises;
    int pulses;
    bit prev_busy;
    logic [31:0] a;

    repeat (2) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("reset_rdata_u%0d", i), rd_o[i], 0);
      cmp($sformatf("reset_rdy_u%0d", i), rdy_o[i], 0);
      cmp($sformatf("reset_busy_u%0d", i), busy_o[i], 0);
    end
    #2 Reset_n = 1'b1;

    // Write then read.
    access(1'b1, 32'h10, 32'hDEADBEEF);
    cmp("wr_err", r_err[0], 0);
    cmp("wr_keeps_rdata", r_rd[0], 0);
    access(1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("rd_10_u%0d", i), r_rd[i], 32'hDEADBEEF);
      cmp($sformatf("rd_10_err_u%0d", i), r_err[i], 0);
    end

    // Misaligned write is flagged and not performed.
    access(1'b1, 32'h20, 32'h11111111);
    access(1'b1, 32'h22, 32'h22222222);
    cmp("mis_err", r_err[0], 1);
    cmp("mis_keeps_rdata", r_rd[0], 32'hDEADBEEF);
    access(1'b0, 32'h20, 32'h0);
    cmp("rd_20", r_rd[0], 32'h11111111);
    cmp("rd_20_err", r_err[0], 0);

    // A request raised during WAIT and dropped before IDLE is ignored.
    wait_idle();
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    rises = 0; pulses = 0; prev_busy = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge Clk);
      if (c == 1) req = 1'b0;
      if (c == 2) begin req = 1'b1; addr = 32'h20; end
      if (c == 3) req = 1'b0;
      if (rdy_o[0]) pulses++;
      if (busy_o[0] && !prev_busy) rises++;
      prev_busy = busy_o[0];
    end
    cmp("ignored_pulses", pulses, 1);
    cmp("ignored_busy_rises", rises, 0);
    cmp("ignored_rdata", rd_o[0], 32'hDEADBEEF);

    // Aliasing: upper address bits are dropped.
    access(1'b1, 32'h400, 32'hA5A5A5A5);
    access(1'b0, 32'h000, 32'h0);
    for (int i = 0; i < 3; i++) cmp($sformatf("alias_u%0d", i), r_rd[i], 32'hA5A5A5A5);

    // Reset during WAIT abandons a pending write.
    access(1'b1, 32'h04, 32'h12345678);
    wait_idle();
    req = 1'b1; wr = 1'b1; addr = 32'h04; wdata = 32'hCAFEF00D;
    @(posedge Clk);
    #2 Reset_n = 1'b0; req = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("async_rst_busy_u%0d", i), busy_o[i], 0);
      cmp($sformatf("async_rst_rdata_u%0d", i), rd_o[i], 0);
      cmp($sformatf("async_rst_rdy_u%0d", i), rdy_o[i], 0);
    end
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (rdy_o[0] || rdy_o[1] || rdy_o[2]) pulses++;
    end
    cmp("no_rdy_after_abort", pulses, 0);
    access(1'b0, 32'h04, 32'h0);
    for (int i = 0; i < 3; i++) cmp($sformatf("abort_kept_u%0d", i), r_rd[i], 32'h12345678);

    // Random traffic, checked by the model on the LATENCY=2 instance.
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) a = a | ($urandom << 10);
      req = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      addr = a;
      wdata = $urandom;
      if (c == 200) begin
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
      end
    end
    req = 1'b0;
    repeat (12) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle datapath's memory port. It answers the control FSM's read/write requests to a word-organised RAM with a fixed, parameterised wait, which is the latency the control unit's FETCH/MEM_DELAY sequencing is built around. It sits between the datapath's address mux (IorD) and the MDR/IR load path. It returns read data and a one-cycle ready strobe, and flags misaligned accesses instead of performing them.

## Interface
- `ADDR_W`, 8: word-index width; RAM depth is 2**ADDR_W 32-bit words.
- `LATENCY`, 2: wait cycles between request acceptance and response; legal range 1..7.
- `Clk`  in  1: clock; all state changes on rising edge.
- `Reset_n`  in  1: reset; asynchronous, active-low.
- `req`  in  1: request valid; sampled only while `busy`=0.
- `wr`  in  1: 1 = write, 0 = read; captured with `req`.
- `Address`  in  32: byte address; captured with `req`.
- `WriteData`  in  32: write data; captured with `req`.
- `ReadData`  out  32: registered read data.
- `rdy`  out  1: one-cycle response strobe; marks both read data valid and write committed.
- `err`  out  1: qualifies `rdy`; 1 = misaligned request, no access done.
- `busy`  out  1: request in flight; new `req` is ignored.

## Operation
- FSM states:
  - `IDLE`: `busy`=0. When `req`=1, capture `wr`, `Address` and `WriteData`, load the counter with LATENCY-1, and go to `WAIT`.
  - `WAIT`: `busy`=1. Decrement the counter each cycle. When the counter is 0, the next edge goes to `RESP`.
  - `RESP`: `busy`=1, `rdy`=1 for exactly this cycle. The next edge goes to `IDLE` unconditionally.
- Word index = captured `Address[ADDR_W+1:2]`. Address bits above ADDR_W+1 are ignored, so out-of-range addresses alias (wrap modulo depth).
- Misaligned request (`Address[1:0]`≠0):
  - Accepted and timed like a normal request.
  - In `RESP`, `err`=1.
  - No RAM write; `ReadData` is unchanged.
- Aligned read: `ReadData` is loaded from RAM on the edge entering `RESP`. It holds that value until the next aligned read response.
- Aligned write: the RAM word is written on the edge entering `RESP`. `ReadData` is unchanged. A read of the same word issued afterwards returns the new value.
- A `req` held or asserted during `WAIT`/`RESP` is ignored. The requester keeps `req` high until it sees `rdy` if it wants a back-to-back access; that access is accepted in the `IDLE` cycle after `RESP`.
- `err` is 0 whenever `rdy` is 0.

## Timing
- Reset values: state `IDLE`, `ReadData`=0, `rdy`=0, `err`=0, `busy`=0, counter=0. RAM contents are not reset and are undefined until written.
- Reset asserted mid-operation:
  - Abandons the request immediately; outputs take their reset values asynchronously.
  - A pending write is not committed.
  - No `rdy` is produced for the abandoned request.
- Latency: `req` sampled at edge k, then `rdy`=1 during the cycle following edge k+LATENCY. With LATENCY=2 this is 3 cycles from the request cycle to `rdy`.
- Throughput: one access per LATENCY+2 cycles.
- `busy` rises the cycle after acceptance and falls the cycle after `rdy`.
- Registered outputs: `rdy`, `err`, `ReadData`. `busy` is decoded from state. There is no combinational path from any input to any output.

## Structure
- Shared package `mem_pkg`:
  - state enum `{IDLE, WAIT, RESP}`
  - default `ADDR_W` and `LATENCY` constants
  - 32-bit word typedef
  - these are reused by the control unit's testbench.
- Sub-module `mem_array`: single-port RAM, synchronous write, synchronous read, with ports address, write-enable, write data and read data. `mem_responder` holds the FSM, the capture registers, the latency counter and the misalignment check.
- Counter width: 3 bits, sized for LATENCY≤7. An elaboration check rejects LATENCY=0 or LATENCY>7.

## Test plan
- Write then read: write 0xDEADBEEF to 0x10, then read 0x10. Read gives `rdy` with `err`=0 and `ReadData`=0xDEADBEEF; the write response leaves `ReadData` unchanged.
- Latency sweep: for LATENCY=1, 2 and 7, a read sampled at edge k gives `rdy` exactly in the cycle after edge k+LATENCY. `busy` is high for LATENCY+1 cycles.
- Misaligned access: write 0x11111111 to 0x20, then write 0x22222222 to 0x22. The second write returns `rdy`=1 with `err`=1, and a read of 0x20 still returns 0x11111111.
- Ignored request: assert a second `req` (read 0x20) during `WAIT` and drop it before `IDLE`. Only one `rdy` is produced, and `busy` never re-rises.
- Reset mid-write: write 0xCAFEF00D to 0x04 and pull `Reset_n` low during `WAIT`. Outputs go to reset values immediately and no `rdy` appears. A later read of 0x04 returns the value stored before the aborted write.
- Alias: with ADDR_W=8, write 0xA5A5A5A5 to 0x400. A read of 0x000 returns 0xA5A5A5A5.
